// File: rtl/load_store_unit.sv
// load_store_unit
//   Sub-word load/store engine sitting between the control FSM and a word-addressed
//   synchronous memory (read data appears the cycle after mem_rd_en_o). One byte, half
//   or word access is handled at a time. Loads are lane-extracted and sign/zero
//   extended; sub-word stores are done as read-modify-write. Misaligned or
//   illegal-size requests are answered with rsp_err_o and never touch memory.
//   Little-endian.
//
// Ports
//   clk_i, rstn_i      clock, synchronous active-low reset
//   req_*              request handshake (valid/ready) and captured request fields
//   rsp_valid_o        one-cycle response pulse, no backpressure
//   rsp_rdata_o        extended load data (0 for stores and errors)
//   rsp_err_o          misaligned / illegal size, valid with rsp_valid_o
//   mem_addr_o         registered word address, stable for the transaction
//   mem_rd_en_o        one-cycle read strobe
//   mem_wr_en_o        one-cycle full-word write strobe
//   mem_wdata_o        registered write data
//   mem_rdata_i        memory read data (one cycle after mem_rd_en_o)
module load_store_unit #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned BYTE_ADDR_W = ADDR_W + 2
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [1:0]             req_size_i,
    input  logic                   req_unsigned_i,
    input  logic [BYTE_ADDR_W-1:0] req_addr_i,
    input  logic [31:0]            req_wdata_i,
    output logic                   rsp_valid_o,
    output logic [31:0]            rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic                   mem_rd_en_o,
    output logic                   mem_wr_en_o,
    output logic [31:0]            mem_wdata_o,
    input  logic [31:0]            mem_rdata_i
);

    typedef enum logic [2:0] {StIdle, StRead, StData, StWrite, StResp} state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                unsigned_q, unsigned_d;
    logic [1:0]          lane_q, lane_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic                mem_wr_en_q, mem_wr_en_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;

    logic        accept;
    logic        req_err;
    logic [4:0]  lane_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ext_data;
    logic [31:0] merge_mask;
    logic [31:0] merged;

    assign req_ready_o = (state_q == StIdle) && rstn_i;
    assign accept      = req_valid_i && req_ready_o;

    // Illegal size, odd half address, or word address not on a word boundary.
    assign req_err = (req_size_i == 2'b11)
                  || ((req_size_i == 2'b01) && req_addr_i[0])
                  || ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));

    assign lane_shift = {lane_q, 3'b000};

    // Lane extraction and merge work on the word currently on mem_rdata_i (DATA state).
    always_comb begin
        rd_byte = 8'(mem_rdata_i >> lane_shift);
        rd_half = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (size_q)
            2'b00:   ext_data = {{24{rd_byte[7] & ~unsigned_q}}, rd_byte};
            2'b01:   ext_data = {{16{rd_half[15] & ~unsigned_q}}, rd_half};
            default: ext_data = mem_rdata_i;
        endcase
        // Legal halves have lane_q[0]=0, so the shift is 0 or 16.
        merge_mask = ((size_q == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff) << lane_shift;
        merged     = (mem_rdata_i & ~merge_mask) | ((mem_wdata_q << lane_shift) & merge_mask);
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        lane_d      = lane_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_en_d = 1'b0;
        mem_wr_en_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    we_d        = req_we_i;
                    size_d      = req_size_i;
                    unsigned_d  = req_unsigned_i;
                    lane_d      = req_addr_i[1:0];
                    mem_addr_d  = req_addr_i[BYTE_ADDR_W-1:2];
                    mem_wdata_d = req_wdata_i;
                    if (req_err) begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_we_i && (req_size_i == 2'b10)) begin
                        state_d     = StWrite;
                        mem_wr_en_d = 1'b1;
                    end else begin
                        state_d     = StRead;
                        mem_rd_en_d = 1'b1;
                    end
                end
            end
            StRead: begin
                state_d = StData;
            end
            StData: begin
                if (we_q) begin
                    state_d     = StWrite;
                    mem_wr_en_d = 1'b1;
                    mem_wdata_d = merged;
                end else begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ext_data;
                end
            end
            StWrite: begin
                state_d     = StResp;
                rsp_valid_d = 1'b1;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            lane_q      <= 2'b00;
            mem_addr_q  <= '0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_wdata_q <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            lane_q      <= lane_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_rd_en_o = mem_rd_en_q;
    assign mem_wr_en_o = mem_wr_en_q;
    assign mem_wdata_o = mem_wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: synchronous memory with a backdoor preload port, a
// schedule-based reference model (per-cycle expected strobes/responses derived from
// the documented latencies and byte-lane rules), one per-cycle compare process, and
// directed plus randomized traffic including mid-transaction resets.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [9:0]  req_addr = 10'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit #(.ADDR_W(8), .BYTE_ADDR_W(10)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .mem_addr_o     (mem_addr),
        .mem_rd_en_o    (mem_rd_en),
        .mem_wr_en_o    (mem_wr_en),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory with a backdoor port used only while the unit is idle.
    logic [31:0] mem [256];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = 8'h0;
    logic [31:0] bd_data = 32'h0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    int cyc = 0;
    bit rst_seen = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= !rstn;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [256];
    int          exp_rd_addr [int];
    int          exp_wr_addr [int];
    logic [31:0] exp_wr_data [int];
    logic [31:0] exp_rsp_data [int];
    bit          exp_rsp_err [int];
    int          busy_from = 1;
    int          busy_until = 0;
    int          cur_w = 0;
    bit          cur_err = 1'b1;
    int          pend_cyc = -1;
    int          pend_addr = 0;
    logic [31:0] pend_old = 32'h0;

    function automatic bit model_ready();
        return rstn && !(cyc >= busy_from && cyc <= busy_until);
    endfunction

    function automatic int n_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic int first_byte(input logic [1:0] sz, input logic [1:0] lane);
        if (sz == 2'd0) return int'(lane);
        if (sz == 2'd1) return (lane >= 2'd2) ? 2 : 0;
        return 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                               input bit uns, input logic [1:0] lane);
        logic [7:0]  b [4];
        logic [31:0] v;
        logic [31:0] ones;
        int nb;
        int fb;
        for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
        nb = n_bytes(sz);
        fb = first_byte(sz, lane);
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | ({24'h0, b[fb+i]} << (8*i));
        ones = 32'hffff_ffff;
        if (!uns && nb < 4 && b[fb+nb-1][7]) v = v | (ones << (8*nb));
        return v;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [1:0] lane, input logic [31:0] wd);
        logic [7:0]  b [4];
        logic [31:0] v;
        int fb;
        for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
        fb = first_byte(sz, lane);
        for (int i = 0; i < n_bytes(sz); i++) b[fb+i] = wd[8*i +: 8];
        v = 32'h0;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = b[i];
        return v;
    endfunction

    task automatic predict(input bit we, input logic [1:0] sz, input bit uns,
                           input logic [9:0] a, input logic [31:0] wd, input int acc);
        int w;
        logic [1:0] lane;
        bit err;
        w    = int'(a[9:2]);
        lane = a[1:0];
        err  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && lane != 2'd0);
        cur_w     = w;
        cur_err   = err;
        busy_from = acc + 1;
        if (err) begin
            exp_rsp_data[acc+1] = 32'h0;
            exp_rsp_err[acc+1]  = 1'b1;
            busy_until = acc + 1;
        end else if (!we) begin
            exp_rd_addr[acc+1]  = w;
            exp_rsp_data[acc+3] = model_load(ref_mem[w], sz, uns, lane);
            exp_rsp_err[acc+3]  = 1'b0;
            busy_until = acc + 3;
        end else if (sz == 2'd2) begin
            exp_wr_addr[acc+1] = w;
            exp_wr_data[acc+1] = wd;
            pend_cyc = acc + 1; pend_addr = w; pend_old = ref_mem[w];
            ref_mem[w] = wd;
            exp_rsp_data[acc+2] = 32'h0;
            exp_rsp_err[acc+2]  = 1'b0;
            busy_until = acc + 2;
        end else begin
            exp_rd_addr[acc+1] = w;
            exp_wr_addr[acc+3] = w;
            exp_wr_data[acc+3] = model_merge(ref_mem[w], sz, lane, wd);
            pend_cyc = acc + 3; pend_addr = w; pend_old = ref_mem[w];
            ref_mem[w] = exp_wr_data[acc+3];
            exp_rsp_data[acc+4] = 32'h0;
            exp_rsp_err[acc+4]  = 1'b0;
            busy_until = acc + 4;
        end
    endtask

    // Reset sampled at the end of interval r cancels everything scheduled after r.
    task automatic purge(input int r);
        if (pend_cyc > r) ref_mem[pend_addr] = pend_old;
        pend_cyc = -1;
        for (int k = r + 1; k <= r + 8; k++) begin
            if (exp_rd_addr.exists(k)) exp_rd_addr.delete(k);
            if (exp_wr_addr.exists(k)) exp_wr_addr.delete(k);
            if (exp_wr_data.exists(k)) exp_wr_data.delete(k);
            if (exp_rsp_data.exists(k)) exp_rsp_data.delete(k);
            if (exp_rsp_err.exists(k)) exp_rsp_err.delete(k);
        end
        if (busy_until > r) busy_until = r;
    endtask

    // ---------------- per-cycle compare ----------------
    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            bit er, ew, ep;
            er = exp_rd_addr.exists(cyc);
            ew = exp_wr_addr.exists(cyc);
            ep = exp_rsp_data.exists(cyc);
            check("ready", 32'(req_ready), 32'(model_ready()));
            check("rd_en", 32'(mem_rd_en), 32'(er));
            check("wr_en", 32'(mem_wr_en), 32'(ew));
            check("rsp_valid", 32'(rsp_valid), 32'(ep));
            if (er && mem_rd_en) check("rd_addr", 32'(mem_addr), 32'(exp_rd_addr[cyc]));
            if (ew && mem_wr_en) begin
                check("wr_addr", 32'(mem_addr), 32'(exp_wr_addr[cyc]));
                check("wr_data", mem_wdata, exp_wr_data[cyc]);
            end
            if (ep && rsp_valid) begin
                check("rsp_data", rsp_rdata, exp_rsp_data[cyc]);
                check("rsp_err", 32'(rsp_err), 32'(exp_rsp_err[cyc]));
            end
            if (!cur_err && cyc >= busy_from && cyc <= busy_until)
                check("addr_stable", 32'(mem_addr), 32'(cur_w));
            if (rst_seen) begin
                check("rst_rdata", rsp_rdata, 32'h0);
                check("rst_addr", 32'(mem_addr), 32'h0);
                check("rst_wdata", mem_wdata, 32'h0);
                check("rst_err", 32'(rsp_err), 32'h0);
            end
        end
    end

    // Monitor for directed literal checks.
    int          last_rsp_cyc = 0, last_rd_cyc = 0, last_wr_cyc = 0;
    int          rsp_cnt = 0, rd_cnt = 0, wr_cnt = 0;
    logic [31:0] last_rsp_data = 32'h0, last_wr_data = 32'h0;
    logic        last_rsp_err = 1'b0;
    logic [7:0]  last_rd_addr = 8'h0, last_wr_addr = 8'h0;
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            last_rsp_cyc = cyc; last_rsp_data = rsp_rdata; last_rsp_err = rsp_err; rsp_cnt++;
        end
        if (mem_rd_en === 1'b1) begin
            last_rd_cyc = cyc; last_rd_addr = mem_addr; rd_cnt++;
        end
        if (mem_wr_en === 1'b1) begin
            last_wr_cyc = cyc; last_wr_addr = mem_addr; last_wr_data = mem_wdata; wr_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = 8'(a); bd_data = d;
        ref_mem[a] = d;
        step();
        bd_we = 1'b0;
    endtask

    task automatic junk();
        req_valid    = 1'($urandom_range(0, 1));
        req_we       = 1'($urandom_range(0, 1));
        req_size     = 2'($urandom_range(0, 3));
        req_unsigned = 1'($urandom_range(0, 1));
        req_addr     = 10'($urandom);
        req_wdata    = $urandom;
    endtask

    task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [9:0] a, input logic [31:0] wd, output int acc);
        while (!model_ready()) begin
            junk();
            step();
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        acc = cyc;
        predict(we, sz, uns, a, wd, acc);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc <= busy_until) step();
    endtask

    task automatic do_reset(input int hold);
        rstn = 1'b0;
        purge(cyc);
        repeat (hold) begin
            junk();
            step();
        end
        rstn = 1'b1;
        req_valid = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acc;
        int rd0, wr0, rsp0;
        // Reset held while the memory is filled.
        step();
        step();
        chk_en = 1'b1;
        for (int i = 0; i < 256; i++) preload(i, $urandom);
        check("rst_ready_held", 32'(req_ready), 32'h0);
        check("rst_valid_held", 32'(rsp_valid), 32'h0);
        check("rst_strobes_held", 32'({mem_rd_en, mem_wr_en}), 32'h0);
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(req_ready), 32'h1);
        step();

        // Pin the model itself.
        check("pin_load_b", model_load(32'h8899aabb, 2'd0, 1'b0, 2'd2), 32'hffffff99);
        check("pin_load_h", model_load(32'h8899aabb, 2'd1, 1'b0, 2'd2), 32'hffff8899);
        check("pin_merge", model_merge(32'h11223344, 2'd0, 2'd1, 32'h000000ab), 32'h1122ab44);

        // Byte loads, signed and unsigned.
        preload(1, 32'h8899aabb);
        issue(1'b0, 2'd0, 1'b0, 10'h006, 32'h0, acc);
        wait_idle();
        check("lb_rd_lat", 32'(last_rd_cyc - acc), 32'd1);
        check("lb_rsp_lat", 32'(last_rsp_cyc - acc), 32'd3);
        check("lb_data", last_rsp_data, 32'hffffff99);
        issue(1'b0, 2'd0, 1'b1, 10'h006, 32'h0, acc);
        wait_idle();
        check("lbu_data", last_rsp_data, 32'h00000099);

        // Half load and misaligned half.
        issue(1'b0, 2'd1, 1'b0, 10'h006, 32'h0, acc);
        wait_idle();
        check("lh_data", last_rsp_data, 32'hffff8899);
        rd0 = rd_cnt; wr0 = wr_cnt;
        issue(1'b0, 2'd1, 1'b0, 10'h005, 32'h0, acc);
        wait_idle();
        check("lh_mis_err", 32'(last_rsp_err), 32'h1);
        check("lh_mis_lat", 32'(last_rsp_cyc - acc), 32'd1);
        check("lh_mis_nomem", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'h0);

        // Sub-word store read-modify-write.
        preload(2, 32'h11223344);
        issue(1'b1, 2'd0, 1'b0, 10'h009, 32'h000000ab, acc);
        wait_idle();
        step();
        check("sb_rd_lat", 32'(last_rd_cyc - acc), 32'd1);
        check("sb_wr_lat", 32'(last_wr_cyc - acc), 32'd3);
        check("sb_wr_data", last_wr_data, 32'h1122ab44);
        check("sb_rsp_lat", 32'(last_rsp_cyc - acc), 32'd4);
        check("sb_err", 32'(last_rsp_err), 32'h0);
        check("sb_mem", mem[2], 32'h1122ab44);

        // Word store, then illegal size.
        rd0 = rd_cnt; wr0 = wr_cnt;
        issue(1'b1, 2'd2, 1'b0, 10'h00c, 32'hdeadbeef, acc);
        wait_idle();
        step();
        check("sw_wr_lat", 32'(last_wr_cyc - acc), 32'd1);
        check("sw_addr", 32'(last_wr_addr), 32'd3);
        check("sw_rsp_lat", 32'(last_rsp_cyc - acc), 32'd2);
        check("sw_one_strobe", 32'((rd_cnt - rd0) * 16 + (wr_cnt - wr0)), 32'd1);
        check("sw_mem", mem[3], 32'hdeadbeef);
        issue(1'b0, 2'd3, 1'b0, 10'h010, 32'h0, acc);
        wait_idle();
        check("ill_err", 32'(last_rsp_err), 32'h1);
        check("ill_lat", 32'(last_rsp_cyc - acc), 32'd1);
        check("ill_data", last_rsp_data, 32'h0);

        // Top byte address wraps onto the last word.
        preload(255, 32'ha1b2c3d4);
        issue(1'b0, 2'd0, 1'b1, 10'h3ff, 32'h0, acc);
        wait_idle();
        check("wrap_addr", 32'(last_rd_addr), 32'd255);
        check("wrap_data", last_rsp_data, 32'h000000a1);

        // Reset during DATA of a half store aborts it.
        preload(4, 32'h55667788);
        wr0 = wr_cnt; rsp0 = rsp_cnt;
        issue(1'b1, 2'd1, 1'b0, 10'h012, 32'h0000beef, acc);
        step();
        do_reset(2);
        repeat (6) step();
        check("abort_no_wr", 32'(wr_cnt - wr0), 32'h0);
        check("abort_no_rsp", 32'(rsp_cnt - rsp0), 32'h0);
        check("abort_mem", mem[4], 32'h55667788);

        // Randomized traffic with occasional mid-transaction resets.
        for (int t = 0; t < 300; t++) begin
            int sel, w;
            logic [1:0] sz;
            sel = int'($urandom_range(0, 9));
            sz  = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
            w   = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 7));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  {8'(w), 2'($urandom_range(0, 3))}, $urandom, acc);
            if ($urandom_range(0, 24) == 0) begin
                int off;
                off = int'($urandom_range(1, 4));
                while (cyc < acc + off) begin
                    if (!model_ready()) junk(); else req_valid = 1'b0;
                    step();
                end
                do_reset(int'($urandom_range(1, 2)));
            end
            repeat ($urandom_range(0, 2)) begin
                if (model_ready()) req_valid = 1'b0; else junk();
                step();
            end
        end
        req_valid = 1'b0;
        wait_idle();
        repeat (3) step();
        for (int i = 0; i < 256; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
